// File: rtl/crc32_pkg.sv
// Shared constants and state encoding for the bit-serial CRC-32 frame checker.
package crc32_pkg;

   localparam int unsigned CRC32_W   = 32;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned BIT_CNT_W = 3;

   localparam logic [CRC32_W-1:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [CRC32_W-1:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [CRC32_W-1:0] CRC32_XOR_OUT   = 32'hFFFFFFFF;
   localparam logic [CRC32_W-1:0] CRC32_CHECK     = 32'hCBF43926;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCEPT = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_FINAL  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/crc32_bit_step.sv
// Single-bit reflected CRC-32 update; purely combinational so it can be chained
// for a byte-parallel engine.
module crc32_bit_step
   import crc32_pkg::*;
#(
   parameter logic [CRC32_W-1:0] POLY = CRC32_POLY_REFL
) (
   input  logic [CRC32_W-1:0] crc_in,
   input  logic               bit_in,
   output logic [CRC32_W-1:0] crc_out
);

   logic fb;

   assign fb      = crc_in[0] ^ bit_in;
   assign crc_out = (crc_in >> 1) ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc32_frame_checker.sv
// Accepts one frame over valid/ready, shifts each byte LSB first through a CRC-32
// register and reports the final CRC with a mismatch flag against the expected value.
module crc32_frame_checker
   import crc32_pkg::*;
#(
   parameter logic [CRC32_W-1:0] POLY    = CRC32_POLY_REFL,
   parameter logic [CRC32_W-1:0] INIT    = CRC32_INIT,
   parameter logic [CRC32_W-1:0] XOR_OUT = CRC32_XOR_OUT,
   parameter int unsigned        CNT_W   = 16
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               START,
   input  logic [CRC32_W-1:0] EXP_CRC,
   input  logic [BYTE_W-1:0]  DATA_IN,
   input  logic               DATA_VALID,
   input  logic               DATA_LAST,
   output logic               DATA_READY,
   output logic [CRC32_W-1:0] CRC_OUT,
   output logic               CRC_VALID,
   output logic               ERR,
   output logic               BUSY,
   output logic [CNT_W-1:0]   BYTE_COUNT
);

   state_e               state_q, state_d;
   logic [CRC32_W-1:0]   crc_q, crc_d;
   logic [CRC32_W-1:0]   exp_q, exp_d;
   logic [BYTE_W-1:0]    byte_q, byte_d;
   logic                 last_q, last_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [CRC32_W-1:0]   crc_out_q, crc_out_d;
   logic                 crc_valid_q, crc_valid_d;
   logic                 err_q, err_d;
   logic [CNT_W-1:0]     byte_count_q, byte_count_d;

   logic [CRC32_W-1:0]   step_crc;
   logic [CRC32_W-1:0]   crc_final;

   crc32_bit_step #(.POLY(POLY)) u_bit_step (
      .crc_in  (crc_q),
      .bit_in  (byte_q[bit_cnt_q]),
      .crc_out (step_crc)
   );

   assign crc_final = crc_q ^ XOR_OUT;

   // Next-state and datapath update
   always_comb begin
      state_d      = state_q;
      crc_d        = crc_q;
      exp_d        = exp_q;
      byte_d       = byte_q;
      last_d       = last_q;
      bit_cnt_d    = bit_cnt_q;
      crc_out_d    = crc_out_q;
      crc_valid_d  = crc_valid_q;
      err_d        = err_q;
      byte_count_d = byte_count_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               crc_d        = INIT;
               exp_d        = EXP_CRC;
               byte_count_d = '0;
               crc_valid_d  = 1'b0;
               err_d        = 1'b0;
               state_d      = ST_ACCEPT;
            end
         end
         ST_ACCEPT: begin
            if (DATA_VALID) begin
               byte_d    = DATA_IN;
               last_d    = DATA_LAST;
               bit_cnt_d = '0;
               if (byte_count_q != '1) begin
                  byte_count_d = byte_count_q + CNT_W'(1);
               end
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            crc_d     = step_crc;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
               state_d = last_q ? ST_FINAL : ST_ACCEPT;
            end
         end
         ST_FINAL: begin
            crc_out_d   = crc_final;
            err_d       = (crc_final != exp_q);
            crc_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_IDLE;
         crc_q        <= INIT;
         exp_q        <= '0;
         byte_q       <= '0;
         last_q       <= 1'b0;
         bit_cnt_q    <= '0;
         crc_out_q    <= '0;
         crc_valid_q  <= 1'b0;
         err_q        <= 1'b0;
         byte_count_q <= '0;
      end else begin
         state_q      <= state_d;
         crc_q        <= crc_d;
         exp_q        <= exp_d;
         byte_q       <= byte_d;
         last_q       <= last_d;
         bit_cnt_q    <= bit_cnt_d;
         crc_out_q    <= crc_out_d;
         crc_valid_q  <= crc_valid_d;
         err_q        <= err_d;
         byte_count_q <= byte_count_d;
      end
   end

   // Handshake and busy flags decode directly from the state register
   assign DATA_READY = (state_q == ST_ACCEPT);
   assign BUSY       = (state_q == ST_ACCEPT) || (state_q == ST_SHIFT) || (state_q == ST_FINAL);
   assign CRC_OUT    = crc_out_q;
   assign CRC_VALID  = crc_valid_q;
   assign ERR        = err_q;
   assign BYTE_COUNT = byte_count_q;

endmodule
